// File: rtl/e203_exu_wbck_sched.sv
// rtl/e203_exu_wbck_sched.sv - EXU integer write-back scheduler; optional ALU starvation guard via E203_WBCK_STARVE_GUARD_EN
`ifndef E203_XLEN
`define E203_XLEN 32
`endif
`ifndef E203_FLEN
`define E203_FLEN 32
`endif
`ifndef E203_RFIDX_WIDTH
`define E203_RFIDX_WIDTH 5
`endif

module e203_exu_wbck_sched #(
  parameter int STARVE_MAX = 4,
  parameter int CNT_W      = 3
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         alu_wbck_i_valid,
  output logic                         alu_wbck_i_ready,
  input  logic [`E203_XLEN-1:0]        alu_wbck_i_wdat,
  input  logic [`E203_RFIDX_WIDTH-1:0] alu_wbck_i_rdidx,
  input  logic                         longp_wbck_i_valid,
  output logic                         longp_wbck_i_ready,
  input  logic [`E203_FLEN-1:0]        longp_wbck_i_wdat,
  input  logic [4:0]                   longp_wbck_i_flags,
  input  logic [`E203_RFIDX_WIDTH-1:0] longp_wbck_i_rdidx,
  input  logic                         longp_wbck_i_rdfpu,
  output logic                         rf_wbck_o_ena,
  output logic [`E203_XLEN-1:0]        rf_wbck_o_wdat,
  output logic [`E203_RFIDX_WIDTH-1:0] rf_wbck_o_rdidx,
  output logic                         fpu_wbck_o_ena,
  output logic [4:0]                   fpu_wbck_o_flags,
  output logic                         starve_o
);

  logic                         guard_fire;
  logic                         sel_alu;
  logic                         sel_longp;
  logic                         rf_ena_q, rf_ena_d;
  logic                         fpu_ena_q, fpu_ena_d;
  logic [`E203_XLEN-1:0]        wdat_q, wdat_d;
  logic [`E203_RFIDX_WIDTH-1:0] rdidx_q, rdidx_d;
  logic [4:0]                   flags_q, flags_d;

`ifdef E203_WBCK_STARVE_GUARD_EN
  localparam logic [CNT_W-1:0] STARVE_LIM = CNT_W'(STARVE_MAX);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Counts cycles the ALU has been waiting behind the long pipe; saturates at the limit.
  assign guard_fire = alu_wbck_i_valid & longp_wbck_i_valid & (cnt_q == STARVE_LIM);

  always_comb begin
    cnt_d = cnt_q;
    if (sel_alu | ~alu_wbck_i_valid) begin
      cnt_d = '0;
    end else if (cnt_q != STARVE_LIM) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end
`else
  logic unused_cfg;
  assign unused_cfg = (STARVE_MAX == CNT_W);
  assign guard_fire = 1'b0;
`endif

  assign alu_wbck_i_ready   = ~longp_wbck_i_valid | guard_fire;
  assign longp_wbck_i_ready = ~guard_fire;
  assign starve_o           = guard_fire;

  assign sel_alu   = alu_wbck_i_valid & alu_wbck_i_ready;
  assign sel_longp = longp_wbck_i_valid & longp_wbck_i_ready;

  // Data, index and flags hold across idle cycles; only the strobes return to zero.
  always_comb begin
    rf_ena_d  = 1'b0;
    fpu_ena_d = 1'b0;
    wdat_d    = wdat_q;
    rdidx_d   = rdidx_q;
    flags_d   = flags_q;
    if (sel_alu) begin
      rf_ena_d = 1'b1;
      wdat_d   = alu_wbck_i_wdat;
      rdidx_d  = alu_wbck_i_rdidx;
      flags_d  = 5'b0;
    end else if (sel_longp) begin
      rf_ena_d  = ~longp_wbck_i_rdfpu;
      fpu_ena_d = longp_wbck_i_rdfpu;
      wdat_d    = longp_wbck_i_wdat[`E203_XLEN-1:0];
      rdidx_d   = longp_wbck_i_rdidx;
      flags_d   = longp_wbck_i_flags;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rf_ena_q  <= 1'b0;
      fpu_ena_q <= 1'b0;
      wdat_q    <= '0;
      rdidx_q   <= '0;
      flags_q   <= '0;
    end else begin
      rf_ena_q  <= rf_ena_d;
      fpu_ena_q <= fpu_ena_d;
      wdat_q    <= wdat_d;
      rdidx_q   <= rdidx_d;
      flags_q   <= flags_d;
    end
  end

  assign rf_wbck_o_ena    = rf_ena_q;
  assign rf_wbck_o_wdat   = wdat_q;
  assign rf_wbck_o_rdidx  = rdidx_q;
  assign fpu_wbck_o_ena   = fpu_ena_q;
  assign fpu_wbck_o_flags = flags_q;

endmodule

// File: tb/tb_e203_exu_wbck_sched.sv
// tb/tb_e203_exu_wbck_sched.sv - scoreboard bench for e203_exu_wbck_sched (guard expectations follow E203_WBCK_STARVE_GUARD_EN)
`ifndef E203_XLEN
`define E203_XLEN 32
`endif
`ifndef E203_FLEN
`define E203_FLEN 32
`endif
`ifndef E203_RFIDX_WIDTH
`define E203_RFIDX_WIDTH 5
`endif

module tb_e203_exu_wbck_sched;
  localparam int XW   = `E203_XLEN;
  localparam int FW   = `E203_FLEN;
  localparam int RW   = `E203_RFIDX_WIDTH;
  localparam int SMAX = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          alu_wbck_i_valid = 1'b0;
  logic          alu_wbck_i_ready;
  logic [XW-1:0] alu_wbck_i_wdat = '0;
  logic [RW-1:0] alu_wbck_i_rdidx = '0;
  logic          longp_wbck_i_valid = 1'b0;
  logic          longp_wbck_i_ready;
  logic [FW-1:0] longp_wbck_i_wdat = '0;
  logic [4:0]    longp_wbck_i_flags = '0;
  logic [RW-1:0] longp_wbck_i_rdidx = '0;
  logic          longp_wbck_i_rdfpu = 1'b0;
  logic          rf_wbck_o_ena;
  logic [XW-1:0] rf_wbck_o_wdat;
  logic [RW-1:0] rf_wbck_o_rdidx;
  logic          fpu_wbck_o_ena;
  logic [4:0]    fpu_wbck_o_flags;
  logic          starve_o;

  e203_exu_wbck_sched #(.STARVE_MAX(SMAX), .CNT_W(3)) dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .alu_wbck_i_valid   (alu_wbck_i_valid),
    .alu_wbck_i_ready   (alu_wbck_i_ready),
    .alu_wbck_i_wdat    (alu_wbck_i_wdat),
    .alu_wbck_i_rdidx   (alu_wbck_i_rdidx),
    .longp_wbck_i_valid (longp_wbck_i_valid),
    .longp_wbck_i_ready (longp_wbck_i_ready),
    .longp_wbck_i_wdat  (longp_wbck_i_wdat),
    .longp_wbck_i_flags (longp_wbck_i_flags),
    .longp_wbck_i_rdidx (longp_wbck_i_rdidx),
    .longp_wbck_i_rdfpu (longp_wbck_i_rdfpu),
    .rf_wbck_o_ena      (rf_wbck_o_ena),
    .rf_wbck_o_wdat     (rf_wbck_o_wdat),
    .rf_wbck_o_rdidx    (rf_wbck_o_rdidx),
    .fpu_wbck_o_ena     (fpu_wbck_o_ena),
    .fpu_wbck_o_flags   (fpu_wbck_o_flags),
    .starve_o           (starve_o)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic          rf;
    logic          fpu;
    logic [XW-1:0] wdat;
    logic [RW-1:0] idx;
    logic [4:0]    flags;
  } exp_t;

  exp_t sb[$];
  exp_t m_out = '0;
  exp_t mon_e;
  exp_t mon_got;
  int   m_cnt = 0;
  int   tests_run = 0;
  int   failures = 0;

  // Output-side scoreboard: one expected record per driven cycle, checked one cycle later.
  always @(negedge clk) begin
    if (rst_n && sb.size() > 0) begin
      mon_e   = sb.pop_front();
      mon_got = {rf_wbck_o_ena, fpu_wbck_o_ena, rf_wbck_o_wdat, rf_wbck_o_rdidx, fpu_wbck_o_flags};
      tests_run++;
      if (mon_got !== mon_e) begin
        failures++;
        $display("FAIL wbck_out got rf=%0b fpu=%0b wdat=%h idx=%0d flags=%b required rf=%0b fpu=%0b wdat=%h idx=%0d flags=%b",
                 mon_got.rf, mon_got.fpu, mon_got.wdat, mon_got.idx, mon_got.flags,
                 mon_e.rf, mon_e.fpu, mon_e.wdat, mon_e.idx, mon_e.flags);
      end
    end
  end

  task automatic drive(input logic av, input logic [XW-1:0] aw, input logic [RW-1:0] ai,
                       input logic lv, input logic [FW-1:0] lw, input logic [4:0] lf,
                       input logic [RW-1:0] li, input logic lfpu,
                       output logic e_ar, output logic e_lr, output logic e_st);
    logic gf, sa, sl;
    @(negedge clk);
    alu_wbck_i_valid   = av;
    alu_wbck_i_wdat    = aw;
    alu_wbck_i_rdidx   = ai;
    longp_wbck_i_valid = lv;
    longp_wbck_i_wdat  = lw;
    longp_wbck_i_flags = lf;
    longp_wbck_i_rdidx = li;
    longp_wbck_i_rdfpu = lfpu;
    #1;
`ifdef E203_WBCK_STARVE_GUARD_EN
    gf = av & lv & (m_cnt == SMAX);
`else
    gf = 1'b0;
`endif
    e_ar = ~lv | gf;
    e_lr = ~gf;
    e_st = gf;
    sa = av & e_ar;
    sl = lv & e_lr;
    if (sa || !av) m_cnt = 0;
    else if (m_cnt < SMAX) m_cnt++;
    m_out.rf  = sa | (sl & ~lfpu);
    m_out.fpu = sl & lfpu;
    if (sa) begin
      m_out.wdat = aw; m_out.idx = ai; m_out.flags = 5'b0;
    end else if (sl) begin
      m_out.wdat = lw[XW-1:0]; m_out.idx = li; m_out.flags = lf;
    end
    sb.push_back(m_out);
  endtask

  task automatic test_reset();
    #1;
    tests_run++;
    if ({rf_wbck_o_ena, fpu_wbck_o_ena, rf_wbck_o_wdat, rf_wbck_o_rdidx, fpu_wbck_o_flags, starve_o} !== '0) begin
      failures++;
      $display("FAIL reset_outputs got rf=%0b fpu=%0b wdat=%h idx=%0d flags=%b starve=%0b required all 0",
               rf_wbck_o_ena, fpu_wbck_o_ena, rf_wbck_o_wdat, rf_wbck_o_rdidx, fpu_wbck_o_flags, starve_o);
    end
    tests_run++;
    if ({alu_wbck_i_ready, longp_wbck_i_ready} !== 2'b11) begin
      failures++;
      $display("FAIL reset_ready got %b required 11", {alu_wbck_i_ready, longp_wbck_i_ready});
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_alu_only();
    logic ar, lr, st;
    drive(1'b1, 32'h1234_5678, 5, 1'b0, '0, 5'b0, 0, 1'b0, ar, lr, st);
    tests_run++;
    if (alu_wbck_i_ready !== 1'b1 || {alu_wbck_i_ready, longp_wbck_i_ready, starve_o} !== {ar, lr, st}) begin
      failures++;
      $display("FAIL alu_only_ready got %b required %b", {alu_wbck_i_ready, longp_wbck_i_ready, starve_o}, {ar, lr, st});
    end
    drive(1'b0, '0, 0, 1'b0, '0, 5'b0, 0, 1'b0, ar, lr, st);
  endtask

  task automatic test_conflict();
    logic ar, lr, st;
    drive(1'b1, 32'hAAAA_0001, 3, 1'b1, 32'hDEAD_BEEF, 5'b0, 7, 1'b0, ar, lr, st);
    tests_run++;
    if ({alu_wbck_i_ready, longp_wbck_i_ready} !== 2'b01 || {alu_wbck_i_ready, longp_wbck_i_ready, starve_o} !== {ar, lr, st}) begin
      failures++;
      $display("FAIL conflict_ready got %b required 010", {alu_wbck_i_ready, longp_wbck_i_ready, starve_o});
    end
    drive(1'b1, 32'hAAAA_0001, 3, 1'b0, '0, 5'b0, 0, 1'b0, ar, lr, st);
    tests_run++;
    if (alu_wbck_i_ready !== 1'b1) begin
      failures++;
      $display("FAIL conflict_alu_after got %b required 1", alu_wbck_i_ready);
    end
    drive(1'b0, '0, 0, 1'b0, '0, 5'b0, 0, 1'b0, ar, lr, st);
  endtask

  task automatic test_starvation();
    logic ar, lr, st, pat;
    for (int i = 0; i < 15; i++) begin
      drive(1'b1, XW'(32'h5000_0000 + i), RW'(i + 1), 1'b1, FW'(32'h7000_0000 + i), 5'(i), RW'(i + 16), 1'b0, ar, lr, st);
`ifdef E203_WBCK_STARVE_GUARD_EN
      pat = (i % 5 == 4);
`else
      pat = 1'b0;
`endif
      tests_run++;
      if ({alu_wbck_i_ready, longp_wbck_i_ready, starve_o} !== {pat, ~pat, pat} ||
          {alu_wbck_i_ready, longp_wbck_i_ready, starve_o} !== {ar, lr, st}) begin
        failures++;
        $display("FAIL starve_cycle%0d got %b required %b", i, {alu_wbck_i_ready, longp_wbck_i_ready, starve_o}, {pat, ~pat, pat});
      end
    end
    drive(1'b0, '0, 0, 1'b0, '0, 5'b0, 0, 1'b0, ar, lr, st);
  endtask

  task automatic test_fp_dest();
    logic ar, lr, st;
    drive(1'b0, '0, 0, 1'b1, 32'h3F80_0000, 5'b00101, 9, 1'b1, ar, lr, st);
    tests_run++;
    if (longp_wbck_i_ready !== 1'b1) begin
      failures++;
      $display("FAIL fp_dest_ready got %b required 1", longp_wbck_i_ready);
    end
    drive(1'b0, '0, 0, 1'b0, '0, 5'b0, 0, 1'b0, ar, lr, st);
  endtask

  task automatic test_back_to_back();
    logic ar, lr, st;
    for (int i = 0; i < 6; i++) begin
      drive(1'b1, XW'($urandom), RW'(i), 1'b0, '0, 5'b0, 0, 1'b0, ar, lr, st);
      tests_run++;
      if (alu_wbck_i_ready !== ar) begin
        failures++;
        $display("FAIL b2b_ready%0d got %b required %b", i, alu_wbck_i_ready, ar);
      end
    end
    drive(1'b0, '0, 0, 1'b1, 32'h0BAD_F00D, 5'b10000, 12, 1'b0, ar, lr, st);
    drive(1'b0, '0, 0, 1'b0, '0, 5'b0, 0, 1'b0, ar, lr, st);
  endtask

  task automatic test_reset_mid();
    logic ar, lr, st;
    drive(1'b1, 32'h1111_0000, 2, 1'b1, 32'h2222_0000, 5'b00011, 4, 1'b0, ar, lr, st);
    drive(1'b1, 32'h1111_0000, 2, 1'b1, 32'h2222_0001, 5'b00011, 4, 1'b0, ar, lr, st);
    @(negedge clk);
    #2;
    alu_wbck_i_valid   = 1'b0;
    longp_wbck_i_valid = 1'b0;
    rst_n = 1'b0;
    sb.delete();
    m_out = '0;
    m_cnt = 0;
    #1;
    tests_run++;
    if ({rf_wbck_o_ena, fpu_wbck_o_ena, rf_wbck_o_wdat, rf_wbck_o_rdidx, fpu_wbck_o_flags} !== '0) begin
      failures++;
      $display("FAIL reset_mid got rf=%0b wdat=%h idx=%0d flags=%b required all 0",
               rf_wbck_o_ena, rf_wbck_o_wdat, rf_wbck_o_rdidx, fpu_wbck_o_flags);
    end
    @(negedge clk);
    rst_n = 1'b1;
    drive(1'b1, 32'h1234_5678, 5, 1'b0, '0, 5'b0, 0, 1'b0, ar, lr, st);
    for (int i = 0; i < 6; i++) begin
      drive(1'b1, XW'(32'h6000_0000 + i), 0, 1'b1, FW'(32'h8000_0000 + i), 5'b0, 0, 1'b0, ar, lr, st);
      tests_run++;
      if ({alu_wbck_i_ready, longp_wbck_i_ready, starve_o} !== {ar, lr, st}) begin
        failures++;
        $display("FAIL reset_fresh_count%0d got %b required %b", i, {alu_wbck_i_ready, longp_wbck_i_ready, starve_o}, {ar, lr, st});
      end
    end
    drive(1'b0, '0, 0, 1'b0, '0, 5'b0, 0, 1'b0, ar, lr, st);
  endtask

  initial begin
    test_reset();
    test_alu_only();
    test_conflict();
    test_starvation();
    test_fp_dest();
    test_back_to_back();
    test_reset_mid();
    repeat (2) @(negedge clk);
    #1;
    tests_run++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain got %0d entries required 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests_run, failures);
    $finish;
  end

endmodule
